mux3_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 3-input datapath resource between three requesters.
//  Its registered 2-bit select drives the select input of a 3:1 operand/bus mux (00=A, 01=B, 10=C).
//  A grant is held until the resource signals completion, the owner withdraws, or a hold-timeout expires.

---
 rtl/mux3_rr_arbiter_if.sv | 20 ++
 rtl/mux3_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mux3_rr_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mux3_rr_arbiter_if.sv
// Handshake bundle between three requesters and the shared-resource arbiter.
// The master side drives requests and completion; the slave side is the arbiter.
interface mux3_rr_arbiter_if;
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] select;
    logic       busy;
    logic       timeout;

    modport master (
        output req, done,
        input  gnt, select, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, select, busy, timeout
    );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one 3:1 muxed resource between requesters A/B/C.
// A grant lasts until done, until the owner withdraws its request, or until
// MAX_HOLD cycles have elapsed. Release re-arbitrates in the same edge so
// back-to-back grants have no idle bubble.
module mux3_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNTWIDTH = 5
) (
    input logic                clk,
    input logic                rst,
    mux3_rr_arbiter_if.slave   bus
);

    localparam logic [CNTWIDTH-1:0] HOLD_LAST = CNTWIDTH'(MAX_HOLD - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state;
    logic [2:0]          gnt_r;
    logic [1:0]          sel_r;
    logic                busy_r;
    logic                timeout_r;
    logic [CNTWIDTH-1:0] cnt;
    logic [1:0]          last;

    logic [1:0]          pick_ptr;
    logic [1:0]          winner;
    logic                own_req;
    logic                hold_end;
    logic                release_now;

    // First requester after ptr wins, wrapping C->A; ptr itself is lowest.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
        logic [1:0] w;
        w = 2'd0;
        case (ptr)
            2'd0:    w = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd1:    w = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: w = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
        return w;
    endfunction

    // Arbitration result and release conditions for the current cycle.
    always_comb begin
        // While owning, the current owner is the one being released, so it
        // becomes the lowest priority for the back-to-back re-grant.
        pick_ptr    = (state == OWN) ? sel_r : last;
        winner      = rr_pick(bus.req, pick_ptr);
        own_req     = |(bus.req & gnt_r);
        hold_end    = (cnt == HOLD_LAST);
        release_now = (state == OWN) && (bus.done || !own_req || hold_end);
    end

    // Grant FSM with registered grant, select, busy and timeout outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_r     <= 3'b000;
            sel_r     <= 2'b00;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            cnt       <= '0;
            last      <= 2'd2;
        end else begin
            timeout_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state  <= OWN;
                        gnt_r  <= 3'b001 << winner;
                        sel_r  <= winner;
                        busy_r <= 1'b1;
                        cnt    <= '0;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        last      <= sel_r;
                        // done takes precedence over a coincident hold expiry
                        timeout_r <= hold_end && !bus.done;
                        if (|bus.req) begin
                            gnt_r <= 3'b001 << winner;
                            sel_r <= winner;
                            cnt   <= '0;
                        end else begin
                            state  <= IDLE;
                            gnt_r  <= 3'b000;
                            busy_r <= 1'b0;
                            cnt    <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.select  = sel_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed + randomized bench for mux3_rr_arbiter against a cycle-level
// behavioural model that tracks owner / last owner / hold age as integers.
module tb_mux3_rr_arbiter;

    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    // reference model state
    int   m_owner;   // -1 = no grant
    int   m_last;
    int   m_age;
    int   m_sel;
    int   m_to;

    mux3_rr_arbiter_if bus_if ();

    mux3_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNTWIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int after);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (after + k) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 2; m_age = 0; m_sel = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic [2:0] r, input logic d);
        int w;
        m_to = 0;
        if (m_owner < 0) begin
            w = pick(r, m_last);
            if (w >= 0) begin m_owner = w; m_sel = w; m_age = 0; end
        end else if (d || !r[m_owner] || m_age == MAX_HOLD - 1) begin
            m_to   = (!d && m_age == MAX_HOLD - 1) ? 1 : 0;
            m_last = m_owner;
            w = pick(r, m_owner);
            m_owner = w;
            m_age = 0;
            if (w >= 0) m_sel = w;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_model();
        logic [2:0] eg;
        eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        chk("gnt",     8'(bus_if.gnt),     8'(eg));
        chk("select",  8'(bus_if.select),  8'(m_sel));
        chk("busy",    8'(bus_if.busy),    8'(m_owner >= 0));
        chk("timeout", 8'(bus_if.timeout), 8'(m_to));
        chk("onehot",  8'($countones(bus_if.gnt) <= 1), 8'd1);
    endtask

    task automatic step(input logic [2:0] r, input logic d);
        @(negedge clk);
        bus_if.req  = r;
        bus_if.done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus_if.req = 3'b000; bus_if.done = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus_if.req  = 3'b000;
        bus_if.done = 1'b0;
        model_reset();
        #1;
        chk("rst_gnt",     8'(bus_if.gnt),     8'h00);
        chk("rst_select",  8'(bus_if.select),  8'h00);
        chk("rst_busy",    8'(bus_if.busy),    8'h00);
        chk("rst_timeout", 8'(bus_if.timeout), 8'h00);
        #11 rst = 1'b0;

        // 1) single requester, one-cycle latency, done releases to idle
        step(3'b001, 1'b0);
        chk("t1_gnt", 8'(bus_if.gnt), 8'h01);
        chk("t1_sel", 8'(bus_if.select), 8'h00);
        step(3'b001, 1'b0);
        step(3'b001, 1'b0);
        step(3'b000, 1'b1);
        chk("t1_rel", 8'(bus_if.gnt), 8'h00);

        // 2) all requesting, done on the 2nd cycle of each grant: A,B,C,A,B,C
        do_reset();
        step(3'b111, 1'b0);
        for (int g = 0; g < 6; g++) begin
            chk("t2_order", 8'(bus_if.gnt), 8'(3'b001 << (g % 3)));
            step(3'b111, 1'b0);
            step(3'b111, 1'b1);
            chk("t2_nogap", 8'(bus_if.busy), 8'h01);
        end

        // 3) handoff A->B on done, select holds B's value in idle
        do_reset();
        step(3'b001, 1'b0);
        step(3'b011, 1'b1);
        chk("t3_gnt", 8'(bus_if.gnt), 8'h02);
        chk("t3_sel", 8'(bus_if.select), 8'h01);
        step(3'b000, 1'b1);
        chk("t3_idle", 8'(bus_if.busy), 8'h00);
        chk("t3_hold", 8'(bus_if.select), 8'h01);

        // 4) hold timeout after MAX_HOLD grant cycles, C gets the resource next
        do_reset();
        step(3'b101, 1'b0);
        for (int i = 1; i < MAX_HOLD; i++) step(3'b101, 1'b0);
        chk("t4_still", 8'(bus_if.gnt), 8'h01);
        step(3'b101, 1'b0);
        chk("t4_to",  8'(bus_if.timeout), 8'h01);
        chk("t4_gnt", 8'(bus_if.gnt), 8'h04);
        step(3'b100, 1'b0);
        chk("t4_pulse", 8'(bus_if.timeout), 8'h00);

        // 5) done at the last hold cycle beats timeout; withdrawal releases quietly
        do_reset();
        step(3'b001, 1'b0);
        for (int i = 1; i < MAX_HOLD; i++) step(3'b001, 1'b0);
        step(3'b001, 1'b1);
        chk("t5_done_wins", 8'(bus_if.timeout), 8'h00);
        step(3'b001, 1'b0);
        step(3'b000, 1'b0);
        chk("t5_abort_gnt", 8'(bus_if.gnt), 8'h00);
        chk("t5_abort_to",  8'(bus_if.timeout), 8'h00);

        // 6) asynchronous reset in the middle of a grant
        step(3'b010, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t6_gnt",  8'(bus_if.gnt), 8'h00);
        chk("t6_busy", 8'(bus_if.busy), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(3'b100, 1'b0);
        chk("t6_c", 8'(bus_if.gnt), 8'h04);

        // randomized traffic: sticky-ish requests, sparse done pulses
        begin
            logic [2:0] r;
            r = 3'b000;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
                step(r, ($urandom_range(0, 5) == 0));
                chk("rnd_selmatch", 8'(bus_if.busy ? (bus_if.gnt == (3'b001 << bus_if.select)) : 1'b1), 8'h01);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
